// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace multiplier.
// The row-count helpers size the carry-save tree for any operand width.
package wallace_pkg;

  localparam int W_DEF     = 8;
  localparam int TAG_W_DEF = 4;
  localparam int LATENCY   = 3;

  // Baugh-Wooley correction: +2^w + 2^(2w-1), taken modulo 2^(2w).
  function automatic logic [63:0] bw_corr(input int w);
    return (64'(1) << w) | (64'(1) << (2 * w - 1));
  endfunction

  function automatic int rows_after(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) r = 2 * (r / 3) + r % 3;
    return r;
  endfunction

  function automatic int num_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + r % 3;
      l++;
    end
    return l;
  endfunction

  function automatic int row_offset(input int n, input int lvl);
    int o;
    o = 0;
    for (int i = 0; i < lvl; i++) o += rows_after(n, i);
    return o;
  endfunction

endpackage

// File: rtl/wallace_mul_pipe_if.sv
// Operand/result stream bundle for wallace_mul_pipe.
// A beat moves when valid && ready on a rising edge; a producer holds valid and payload until it moves.
interface wallace_mul_pipe_if #(
  parameter int W     = 8,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_signed;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_p;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag
  );
endinterface

// File: rtl/wallace_fa.sv
// Full-adder cell built from two half adders.
module wallace_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  wallace_ha u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  wallace_ha u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/wallace_ha.sv
// Half-adder cell.
module wallace_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/wallace_tree_csa.sv
// Combinational Baugh-Wooley partial products reduced by a Wallace tree of 3:2 rows
// down to a sum row and a carry row (2W bits each, modulo 2^(2W)).
module wallace_tree_csa
  import wallace_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           sgn,
  output logic [2*W-1:0] row_s,
  output logic [2*W-1:0] row_c
);
  localparam int NR  = W + 1;
  localparam int NL  = num_levels(NR);
  localparam int TOT = row_offset(NR, NL) + 2;
  localparam logic [63:0]    CORR64 = bw_corr(W);
  localparam logic [2*W-1:0] CORR   = CORR64[2*W-1:0];

  // All levels share one flat row store; level l starts at row_offset(NR, l).
  wire [2*W-1:0] rows [TOT];

  for (genvar i = 0; i < W; i++) begin : g_pp
    logic [W-1:0] inv, ppb;
    // Invert exactly the terms where one (not both) of the bits is an operand MSB.
    assign inv = (i == W - 1) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    assign ppb = (a & {W{b[i]}}) ^ (inv & {W{sgn}});
    assign rows[i] = {{W{1'b0}}, ppb} << i;
  end
  assign rows[W] = sgn ? CORR : '0;

  for (genvar l = 0; l < NL; l++) begin : g_lvl
    localparam int N  = rows_after(NR, l);
    localparam int NG = N / 3;
    localparam int IB = row_offset(NR, l);
    localparam int OB = row_offset(NR, l + 1);

    for (genvar g = 0; g < NG; g++) begin : g_csa
      wire [2*W-1:0] cy;
      logic          cy_unused;
      for (genvar k = 0; k < 2 * W; k++) begin : g_bit
        wallace_fa u_fa (
          .a (rows[IB+3*g][k]),
          .b (rows[IB+3*g+1][k]),
          .ci(rows[IB+3*g+2][k]),
          .s (rows[OB+2*g][k]),
          .co(cy[k])
        );
      end
      assign rows[OB+2*g+1] = {cy[2*W-2:0], 1'b0};
      assign cy_unused = cy[2*W-1];
    end

    for (genvar r = 0; r < N % 3; r++) begin : g_pass
      assign rows[OB+2*NG+r] = rows[IB+3*NG+r];
    end
  end

  assign row_s = rows[TOT-2];
  assign row_c = rows[TOT-1];
endmodule

// File: rtl/wallace_mul_pipe.sv
// Three-stage signed/unsigned multiplier: operand capture, Wallace reduction to two rows,
// final carry-propagate add. One global advance moves or holds every stage together.
module wallace_mul_pipe
  import wallace_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  wallace_mul_pipe_if.slave bus
);
  logic             s1_v, s2_v, s3_v;
  logic [W-1:0]     s1_a, s1_b;
  logic             s1_sgn;
  logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;
  logic [2*W-1:0]   s2_s, s2_c, s3_p;
  logic [2*W-1:0]   tree_s, tree_c;
  logic             advance;

  assign advance      = !s3_v || bus.out_ready;
  assign bus.in_ready = advance && !rst;

  wallace_tree_csa #(.W(W)) u_tree (
    .a    (s1_a),
    .b    (s1_b),
    .sgn  (s1_sgn),
    .row_s(tree_s),
    .row_c(tree_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_sgn <= 1'b0;
      s1_tag <= '0;
      s2_v   <= 1'b0;
      s2_s   <= '0;
      s2_c   <= '0;
      s2_tag <= '0;
      s3_v   <= 1'b0;
      s3_p   <= '0;
      s3_tag <= '0;
    end else if (advance) begin
      s1_v   <= bus.in_valid;
      s1_a   <= bus.in_a;
      s1_b   <= bus.in_b;
      s1_sgn <= bus.in_signed;
      s1_tag <= bus.in_tag;
      s2_v   <= s1_v;
      s2_s   <= tree_s;
      s2_c   <= tree_c;
      s2_tag <= s1_tag;
      s3_v   <= s2_v;
      s3_p   <= s2_s + s2_c;
      s3_tag <= s2_tag;
    end
  end

  assign bus.out_valid = s3_v;
  assign bus.out_p     = s3_p;
  assign bus.out_tag   = s3_tag;
endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Bench for wallace_mul_pipe: directed W=8 vectors plus random W=4 / W=16 streams,
// each checked by a queue-based scoreboard drained by an independent monitor.
module tb_wallace_mul_pipe;
  import wallace_pkg::*;

  localparam int TW     = 4;
  localparam int N_RAND = 10000;

  logic clk = 1'b0;
  logic rst8, rst_r;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_lat = 1'b0;

  logic [2*8+TW-1:0]  exp_q8[$];
  int                 acc_q8[$];
  logic [2*4+TW-1:0]  exp_q4[$];
  logic [2*16+TW-1:0] exp_q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wallace_mul_pipe_if #(.W(8),  .TAG_W(TW)) b8  ();
  wallace_mul_pipe_if #(.W(4),  .TAG_W(TW)) b4  ();
  wallace_mul_pipe_if #(.W(16), .TAG_W(TW)) b16 ();

  wallace_mul_pipe #(.W(8),  .TAG_W(TW)) dut8  (.clk(clk), .rst(rst8),  .bus(b8));
  wallace_mul_pipe #(.W(4),  .TAG_W(TW)) dut4  (.clk(clk), .rst(rst_r), .bus(b4));
  wallace_mul_pipe #(.W(16), .TAG_W(TW)) dut16 (.clk(clk), .rst(rst_r), .bus(b16));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- W=8 driver tasks ----------------
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [TW-1:0] t, input logic [15:0] p);
    int w;
    w = 0;
    @(negedge clk);
    b8.in_valid  = 1'b1;
    b8.in_a      = a;
    b8.in_b      = b;
    b8.in_signed = s;
    b8.in_tag    = t;
    #1;
    while (!b8.in_ready && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("send8_accept", b8.in_ready, 1);
    if (b8.in_ready) begin
      exp_q8.push_back({t, p});
      acc_q8.push_back(cyc);
    end
  endtask

  task automatic idle8();
    @(negedge clk);
    b8.in_valid = 1'b0;
  endtask

  task automatic drain8();
    int w;
    w = 0;
    while (exp_q8.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("drain8_empty", exp_q8.size(), 0);
  endtask

  task automatic run_directed();
    logic [7:0]  ta[4];
    logic [7:0]  tb_[4];
    logic        ts[4];
    logic [15:0] tp[4];
    ta  = '{8'd12, 8'hF9, 8'd0, 8'd127};
    tb_ = '{8'd34, 8'd9, 8'd255, 8'd127};
    ts  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tp  = '{16'h0198, 16'hFFC1, 16'h0000, 16'h3F01};

    // reset state
    #1;
    chk("rst_in_ready_low", b8.in_ready, 0);
    chk("rst_out_valid", b8.out_valid, 0);
    @(negedge clk);
    rst8 = 1'b0;
    #1;
    chk("post_rst_out_valid", b8.out_valid, 0);
    chk("post_rst_out_p", b8.out_p, 0);
    chk("post_rst_out_tag", b8.out_tag, 0);
    chk("post_rst_in_ready", b8.in_ready, 1);

    // single unsigned corner, exact latency
    chk_lat = 1'b1;
    b8.out_ready = 1'b1;
    send8(8'd255, 8'd255, 1'b0, 4'd3, 16'hFE01);
    idle8();
    drain8();

    // signed corners back-to-back, then mixed modes
    send8(8'h80, 8'h80, 1'b1, 4'd4, 16'h4000);
    send8(8'h80, 8'h7F, 1'b1, 4'd5, 16'hC080);
    send8(8'hFF, 8'hFF, 1'b1, 4'd6, 16'h0001);
    send8(8'd200, 8'd3, 1'b0, 4'd7, 16'h0258);
    send8(8'd5, 8'hFD, 1'b1, 4'd8, 16'hFFF1);
    send8(8'hFF, 8'hFF, 1'b0, 4'd9, 16'hFE01);
    send8(8'h80, 8'h01, 1'b1, 4'd10, 16'hFF80);
    send8(8'h00, 8'hAB, 1'b0, 4'd11, 16'h0000);
    idle8();
    drain8();
    chk_lat = 1'b0;

    // stream 4 beats, consumer stalls for cycles 4..7
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      b8.out_ready = !(t >= 4 && t <= 7);
      if (t < 4) begin
        b8.in_valid  = 1'b1;
        b8.in_a      = ta[t];
        b8.in_b      = tb_[t];
        b8.in_signed = ts[t];
        b8.in_tag    = 4'(12 + t);
      end else begin
        b8.in_valid = 1'b0;
      end
      #1;
      if (t < 4) begin
        chk("stall_accept", b8.in_ready, 1);
        if (b8.in_ready) begin
          exp_q8.push_back({4'(12 + t), tp[t]});
          acc_q8.push_back(cyc);
        end
      end
      if (t >= 4 && t <= 7) chk("stall_in_ready", b8.in_ready, 0);
    end
    b8.out_ready = 1'b1;
    drain8();

    // reset with two beats in flight
    @(negedge clk);
    b8.in_valid = 1'b1; b8.in_a = 8'd10; b8.in_b = 8'd10; b8.in_signed = 1'b0; b8.in_tag = 4'd1;
    #1 chk("rstflight_accept0", b8.in_ready, 1);
    @(negedge clk);
    b8.in_a = 8'd20; b8.in_b = 8'd20; b8.in_tag = 4'd2;
    #1 chk("rstflight_accept1", b8.in_ready, 1);
    @(negedge clk);
    b8.in_valid = 1'b0;
    rst8 = 1'b1;
    #1 chk("rstflight_in_ready_low", b8.in_ready, 0);
    @(negedge clk);
    rst8 = 1'b0;
    #1;
    chk("rstflight_out_valid", b8.out_valid, 0);
    chk("rstflight_out_p", b8.out_p, 0);
    chk("rstflight_out_tag", b8.out_tag, 0);
    chk("rstflight_in_ready", b8.in_ready, 1);
    repeat (8) @(negedge clk);
    chk_lat = 1'b1;
    send8(8'd3, 8'd5, 1'b0, 4'd9, 16'h000F);
    idle8();
    drain8();
    chk_lat = 1'b0;
  endtask

  // ---------------- random streams ----------------
  task automatic run_rand4();
    int sent, guard, w;
    bit acc;
    longint r;
    sent = 0; guard = 0; acc = 1'b0;
    while (sent < N_RAND && guard < 60000) begin
      @(negedge clk);
      guard++;
      if (acc) b4.in_valid = 1'b0;
      acc = 1'b0;
      b4.out_ready = ($urandom_range(0, 3) != 0);
      if (!b4.in_valid && $urandom_range(0, 3) != 0) begin
        b4.in_valid  = 1'b1;
        b4.in_a      = 4'($urandom_range(0, 15));
        b4.in_b      = 4'($urandom_range(0, 15));
        b4.in_signed = 1'($urandom_range(0, 1));
        b4.in_tag    = 4'(sent);
      end
      #1;
      if (b4.in_valid && b4.in_ready) begin
        acc = 1'b1;
        if (b4.in_signed) r = longint'($signed(b4.in_a)) * longint'($signed(b4.in_b));
        else              r = longint'(b4.in_a) * longint'(b4.in_b);
        exp_q4.push_back({b4.in_tag, r[7:0]});
        sent++;
      end
    end
    @(negedge clk);
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b1;
    chk("rand4_sent", sent, N_RAND);
    w = 0;
    while (exp_q4.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rand4_drain", exp_q4.size(), 0);
  endtask

  task automatic run_rand16();
    int sent, guard, w;
    bit acc;
    longint r;
    sent = 0; guard = 0; acc = 1'b0;
    while (sent < N_RAND && guard < 60000) begin
      @(negedge clk);
      guard++;
      if (acc) b16.in_valid = 1'b0;
      acc = 1'b0;
      b16.out_ready = ($urandom_range(0, 3) != 0);
      if (!b16.in_valid && $urandom_range(0, 3) != 0) begin
        b16.in_valid  = 1'b1;
        b16.in_a      = 16'($urandom_range(0, 65535));
        b16.in_b      = 16'($urandom_range(0, 65535));
        b16.in_signed = 1'($urandom_range(0, 1));
        b16.in_tag    = 4'(sent);
      end
      #1;
      if (b16.in_valid && b16.in_ready) begin
        acc = 1'b1;
        if (b16.in_signed) r = longint'($signed(b16.in_a)) * longint'($signed(b16.in_b));
        else               r = longint'(b16.in_a) * longint'(b16.in_b);
        exp_q16.push_back({b16.in_tag, r[31:0]});
        sent++;
      end
    end
    @(negedge clk);
    b16.in_valid  = 1'b0;
    b16.out_ready = 1'b1;
    chk("rand16_sent", sent, N_RAND);
    w = 0;
    while (exp_q16.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rand16_drain", exp_q16.size(), 0);
  endtask

  // ---------------- monitors ----------------
  initial begin : mon8
    logic [15:0]       held_p;
    logic [TW-1:0]     held_t;
    bit                holding;
    logic [2*8+TW-1:0] e;
    int                a;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (holding) begin
        chk("hold_valid", b8.out_valid, 1);
        chk("hold_p", b8.out_p, held_p);
        chk("hold_tag", b8.out_tag, held_t);
      end
      holding = b8.out_valid && !b8.out_ready;
      held_p  = b8.out_p;
      held_t  = b8.out_tag;
      if (b8.out_valid && b8.out_ready) begin
        chk("out8_expected", exp_q8.size() != 0, 1);
        if (exp_q8.size() != 0) begin
          e = exp_q8.pop_front();
          a = acc_q8.pop_front();
          chk("out8_p", b8.out_p, e[15:0]);
          chk("out8_tag", b8.out_tag, e[2*8+TW-1:16]);
          if (chk_lat) chk("out8_latency", cyc - a, LATENCY);
        end
      end
    end
  end

  initial begin : mon4
    logic [2*4+TW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (b4.out_valid && b4.out_ready) begin
        chk("out4_expected", exp_q4.size() != 0, 1);
        if (exp_q4.size() != 0) begin
          e = exp_q4.pop_front();
          chk("out4_tag_p", {b4.out_tag, b4.out_p}, e);
        end
      end
    end
  end

  initial begin : mon16
    logic [2*16+TW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (b16.out_valid && b16.out_ready) begin
        chk("out16_expected", exp_q16.size() != 0, 1);
        if (exp_q16.size() != 0) begin
          e = exp_q16.pop_front();
          chk("out16_tag_p", {b16.out_tag, b16.out_p}, e);
        end
      end
    end
  end

  // ---------------- clock/reset and sequencing ----------------
  initial begin
    rst8  = 1'b1;
    rst_r = 1'b1;
    b8.in_valid  = 1'b0; b8.in_a  = '0; b8.in_b  = '0; b8.in_signed  = 1'b0; b8.in_tag  = '0; b8.out_ready  = 1'b1;
    b4.in_valid  = 1'b0; b4.in_a  = '0; b4.in_b  = '0; b4.in_signed  = 1'b0; b4.in_tag  = '0; b4.out_ready  = 1'b1;
    b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_signed = 1'b0; b16.in_tag = '0; b16.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_r = 1'b0;
    fork
      run_directed();
      run_rand4();
      run_rand16();
    join
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
